// File: rtl/watch_pkg.sv
// Shared encodings for the watch time-of-day controller: mode, edit field, field limits, colon pattern.
package watch_pkg;

    typedef enum logic {
        MODE_CLOCK = 1'b0,
        MODE_SETUP = 1'b1
    } mode_e;

    localparam logic [1:0] POS_SEC  = 2'd0;
    localparam logic [1:0] POS_MIN  = 2'd1;
    localparam logic [1:0] POS_HOUR = 2'd2;

    localparam logic [5:0] SEC_MAX  = 6'd59;
    localparam logic [5:0] MIN_MAX  = 6'd59;
    localparam logic [5:0] HOUR_MAX = 6'd23;

    localparam logic [5:0] DP_SEP   = 6'b010100;

    // Two display digits per field; an out-of-range pos selects nothing.
    function automatic logic [5:0] field_mask(input logic [1:0] pos);
        case (pos)
            POS_SEC:  field_mask = 6'b000011;
            POS_MIN:  field_mask = 6'b001100;
            POS_HOUR: field_mask = 6'b110000;
            default:  field_mask = 6'b000000;
        endcase
    endfunction

endpackage

// File: rtl/wrap_cnt.sv
// Modulo field counter, 0..i_max with wrap; clear beats increment.
// Count registered (1 cycle); carry is combinational in the same cycle as i_inc; no backpressure.
module wrap_cnt (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_inc,
    input  logic       i_clr,
    input  logic [5:0] i_max,
    output logic [5:0] o_cnt,
    output logic       o_carry
);

    logic [5:0] cnt_q, cnt_d;
    logic       at_max;

    // ">=" lets a corrupted count fall back to 0 on its next increment.
    assign at_max  = (cnt_q >= i_max);
    assign o_carry = i_inc && at_max;
    assign o_cnt   = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (i_clr) begin
            cnt_d = 6'd0;
        end else if (i_inc) begin
            cnt_d = at_max ? 6'd0 : cnt_q + 6'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= 6'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/watch_ctrl.sv
// hh:mm:ss time keeper with CLOCK/SETUP mode FSM, blink-blank and colon decimal-point masks.
// All outputs registered, updating on the edge that samples a pulse; inputs are single-cycle pulses, no backpressure.
module watch_ctrl
    import watch_pkg::*;
#(
    parameter int BLINK_DIV = 25000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_tick,
    input  logic       i_sw_mode,
    input  logic       i_sw_pos,
    input  logic       i_sw_inc,
    input  logic       i_sw_clr,
    output logic [5:0] o_sec,
    output logic [5:0] o_min,
    output logic [5:0] o_hour,
    output logic       o_mode,
    output logic [1:0] o_pos,
    output logic [5:0] o_seg_blank,
    output logic [5:0] o_six_dp
);

    localparam int            BW         = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

    mode_e         mode_q, mode_d;
    logic [1:0]    pos_q, pos_d;
    logic          colon_q, colon_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_ph_q, blink_ph_d;
    logic [5:0]    blank_q, blank_d;
    logic [5:0]    dp_q, dp_d;

    logic in_setup;
    logic mode_ev, clr_ev, inc_ev, pos_ev, tick_ev;
    logic sec_inc, min_inc, hour_inc;
    logic sec_carry, min_carry, hour_carry_unused;

    // Priority decode: each event is masked by every higher-priority one.
    assign in_setup = (mode_q == MODE_SETUP);
    assign mode_ev  = i_sw_mode;
    assign clr_ev   = !i_sw_mode && i_sw_clr;
    assign inc_ev   = !i_sw_mode && !i_sw_clr && in_setup && i_sw_inc;
    assign pos_ev   = !i_sw_mode && !i_sw_clr && !i_sw_inc && in_setup && i_sw_pos;
    assign tick_ev  = !i_sw_mode && !i_sw_clr && !in_setup && i_tick;

    // Carries ripple only while running; setup edits one field without carry.
    assign sec_inc  = in_setup ? (inc_ev && pos_q == POS_SEC)  : tick_ev;
    assign min_inc  = in_setup ? (inc_ev && pos_q == POS_MIN)  : sec_carry;
    assign hour_inc = in_setup ? (inc_ev && pos_q == POS_HOUR) : min_carry;

    wrap_cnt u_sec (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (sec_inc),
        .i_clr   (clr_ev),
        .i_max   (SEC_MAX),
        .o_cnt   (o_sec),
        .o_carry (sec_carry)
    );

    wrap_cnt u_min (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (min_inc),
        .i_clr   (1'b0),
        .i_max   (MIN_MAX),
        .o_cnt   (o_min),
        .o_carry (min_carry)
    );

    wrap_cnt u_hour (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_inc   (hour_inc),
        .i_clr   (1'b0),
        .i_max   (HOUR_MAX),
        .o_cnt   (o_hour),
        .o_carry (hour_carry_unused)
    );

    always_comb begin
        mode_d      = mode_q;
        pos_d       = pos_q;
        colon_d     = colon_q;
        blink_cnt_d = blink_cnt_q;
        blink_ph_d  = blink_ph_q;

        case (mode_q)
            MODE_CLOCK: begin
                blink_cnt_d = '0;
                blink_ph_d  = 1'b0;
                if (mode_ev) begin
                    mode_d = MODE_SETUP;
                    pos_d  = POS_SEC;
                end else if (tick_ev) begin
                    colon_d = !colon_q;
                end
            end
            MODE_SETUP: begin
                if (mode_ev) begin
                    mode_d      = MODE_CLOCK;
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b0;
                end else if (pos_ev || inc_ev) begin
                    // Restart blink so the field being edited shows at once.
                    blink_cnt_d = '0;
                    blink_ph_d  = 1'b0;
                    if (pos_ev) begin
                        pos_d = (pos_q >= POS_HOUR) ? POS_SEC : pos_q + 2'd1;
                    end
                end else if (blink_cnt_q >= BLINK_LAST) begin
                    blink_cnt_d = '0;
                    blink_ph_d  = !blink_ph_q;
                end else begin
                    blink_cnt_d = blink_cnt_q + 1'b1;
                end
            end
            default: mode_d = MODE_CLOCK;
        endcase

        blank_d = (mode_d == MODE_SETUP && blink_ph_d) ? field_mask(pos_d) : 6'b000000;
        dp_d    = (mode_d == MODE_CLOCK && colon_d) ? 6'b000000 : DP_SEP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q      <= MODE_CLOCK;
            pos_q       <= POS_SEC;
            colon_q     <= 1'b0;
            blink_cnt_q <= '0;
            blink_ph_q  <= 1'b0;
            blank_q     <= 6'b000000;
            dp_q        <= DP_SEP;
        end else begin
            mode_q      <= mode_d;
            pos_q       <= pos_d;
            colon_q     <= colon_d;
            blink_cnt_q <= blink_cnt_d;
            blink_ph_q  <= blink_ph_d;
            blank_q     <= blank_d;
            dp_q        <= dp_d;
        end
    end

    assign o_mode      = mode_q;
    assign o_pos       = pos_q;
    assign o_seg_blank = blank_q;
    assign o_six_dp    = dp_q;

endmodule
